// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester and the APB slave blocks:
//   - apb_state_e : bus-sequencing FSM state encoding
//   - APB_ADDR_WIDTH / APB_DATA_WIDTH : default bus widths
//   - timer_width() : width of a wait counter able to hold 0..cycles
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } apb_state_e;

    // A zero-cycle timeout still needs a one-bit counter to keep widths legal.
    function automatic int timer_width(input int cycles);
        if (cycles > 0) begin
            return $clog2(cycles + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage : apb_pkg

// File: rtl/apb_wait_timer.sv
// ---------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS cycles spent waiting for pready and flags the last allowed one.
// Ports:
//   clk       in  clock
//   rst       in  asynchronous active-high reset
//   clear_i   in  return the count to zero (has priority over enable_i)
//   enable_i  in  advance the count by one
//   expired_o out count has reached TIMEOUT_CYCLES-1 (never set when 0)
// ---------------------------------------------------------------------------
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int TW = timer_width(TIMEOUT_CYCLES);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: clear wins, otherwise step when enabled.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {TW{1'b0}};
        end else if (enable_i) begin
            count_d = count_q + TW'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {TW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            // The caller aborts in the same cycle, so matching T-1 gives exactly T waits.
            assign expired_o = (count_q == TW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule : apb_wait_timer

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// APB requester: takes one command at a time from a valid/ready port, runs the
// SETUP -> ACCESS sequence towards one of NUM_SLAVES slaves, waits for pready
// (bounded by TIMEOUT_CYCLES) and returns data/error on a valid/ready port.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/cmd_sel/cmd_addr/cmd_wdata  command payload
//   psel/penable/pwrite/paddr/pwdata      APB request signals (registered)
//   pready/prdata                 APB completion from the selected slave
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err             response payload (rdata 0 on writes/errors)
// ---------------------------------------------------------------------------
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int NUM_SLAVES     = 2,
    parameter int SEL_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [SEL_WIDTH-1:0]  cmd_sel,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic [NUM_SLAVES-1:0] psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    // One extra bit so NUM_SLAVES == 2**SEL_WIDTH is representable.
    localparam logic [SEL_WIDTH:0] NUM_SLAVES_W = (SEL_WIDTH + 1)'(NUM_SLAVES);

    apb_state_e            state_q,     state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [NUM_SLAVES-1:0] psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

    logic                  sel_valid_s;
    logic [NUM_SLAVES-1:0] sel_onehot_s;
    logic                  timer_clear_s;
    logic                  timer_enable_s;
    logic                  timer_expired_s;

    assign sel_valid_s = ({1'b0, cmd_sel} < NUM_SLAVES_W);

    // Decode the command's slave index into a one-hot select vector.
    always_comb begin
        sel_onehot_s = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (cmd_sel == SEL_WIDTH'(i)) begin
                sel_onehot_s[i] = 1'b1;
            end else begin
                sel_onehot_s[i] = 1'b0;
            end
        end
    end

    // The timer only runs while ACCESS waits; any other cycle clears it.
    assign timer_clear_s  = (state_q != ACCESS) || pready;
    assign timer_enable_s = (state_q == ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (timer_clear_s),
        .enable_i  (timer_enable_s),
        .expired_o (timer_expired_s)
    );

    // FSM next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    pwrite_d    = cmd_write;
                    cmd_ready_d = 1'b0;
                    if (sel_valid_s) begin
                        psel_d  = sel_onehot_s;
                        state_d = SETUP;
                    end else begin
                        // Unmapped slave: answer with an error, never touch the bus.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = {DATA_WIDTH{1'b0}};
                        state_d     = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end

            ACCESS: begin
                if (pready) begin
                    // Completion takes priority over a coincident timeout.
                    psel_d      = {NUM_SLAVES{1'b0}};
                    penable_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? {DATA_WIDTH{1'b0}} : prdata;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (timer_expired_s) begin
                    psel_d      = {NUM_SLAVES{1'b0}};
                    penable_d   = 1'b0;
                    rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d = ACCESS;
                end
            end

            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean idle bus.
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = {NUM_SLAVES{1'b0}};
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= {NUM_SLAVES{1'b0}};
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= {ADDR_WIDTH{1'b0}};
            pwdata_q    <= {DATA_WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule : apb_master

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator): the counterpart of the team's APB slave blocks.
- Accepts single read/write commands on a valid/ready command port and runs the APB SETUP → ACCESS sequence on the bus.
- Waits for pready, bounded by a timeout, then returns read data and an error flag on a valid/ready response port.
- Sits between the on-chip control logic (host/UART bridge) and the APB slave blocks.

Parameters:
- ADDR_WIDTH, 32, width of paddr/cmd_addr
- DATA_WIDTH, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata
- NUM_SLAVES, 2, number of one-hot psel lines
- SEL_WIDTH, 2, width of cmd_sel; must satisfy 2**SEL_WIDTH >= NUM_SLAVES
- TIMEOUT_CYCLES, 16, max ACCESS cycles without pready before abort; 0 = no timeout

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_sel  in  SEL_WIDTH  target slave index
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- psel  out  NUM_SLAVES  one-hot APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pready  in  1  slave ready
- prdata  in  DATA_WIDTH  slave read data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  1 = timeout or invalid cmd_sel

Behaviour:
- All outputs registered.
- Reset (async, any time): state IDLE, cmd_ready=1, every other output 0, timer 0. An in-flight transfer is dropped with no response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch the command into paddr/pwdata/pwrite and set cmd_ready=0.
  - If cmd_sel < NUM_SLAVES: psel[cmd_sel]=1, go SETUP.
  - Otherwise: no bus activity; rsp_valid=1, rsp_err=1, rsp_rdata=0, go RESP.
- SETUP: exactly one cycle with psel=1, penable=0; set penable=1, go ACCESS.
- ACCESS:
  - psel, penable, paddr, pwrite and pwdata stay stable.
  - Timer increments each cycle pready is 0.
  - pready=1: psel=0, penable=0; rsp_rdata = pwrite ? 0 : prdata; rsp_err=0; rsp_valid=1; go RESP.
  - pready=0 and timer == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): psel=0, penable=0, rsp_err=1, rsp_rdata=0, rsp_valid=1, go RESP.
  - pready wins if it coincides with the timeout cycle.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held until rsp_valid&&rsp_ready.
  - On that handshake: rsp_valid=0, rsp_err=0, cmd_ready=1, timer=0, go IDLE.
- paddr, pwdata and pwrite keep their last values after the transfer; they update only on command accept.
- Latency with zero-wait pready and rsp_ready held high:
  - command accepted at edge N;
  - SETUP in cycle N+1, ACCESS in cycle N+2;
  - rsp_valid high in cycle N+3;
  - next command accepted at edge N+4.
- One outstanding transaction only; cmd_ready=0 from accept until response handshake.
- Timer width clog2(TIMEOUT_CYCLES+1); no wrap, because it is cleared on leaving ACCESS.

Decomposition:
- Shared package apb_pkg: FSM state localparams (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, RESP=2'b11) and default ADDR/DATA widths, also used by the slave blocks.
- One sub-module, apb_wait_timer: clear/enable/expired counter parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write, sel=0, addr=0x0000_0010, wdata=0xDEAD_BEEF, pready tied 1 → psel=2'b01 in SETUP, penable=1 next cycle; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read, sel=1, addr=0x20, pready low 3 ACCESS cycles then high with prdata=0x1234_5678 → psel=2'b10 for 5 cycles total; rsp_rdata=0x1234_5678, rsp_err=0.
- Read with pready never asserted, TIMEOUT_CYCLES=16 → psel drops after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0.
- cmd_sel=2 with NUM_SLAVES=2 → psel stays 0 throughout; rsp_valid the cycle after accept with rsp_err=1.
- rsp_ready held 0 for 4 cycles, then 1 → response stable for 5 cycles; cmd_ready=0 until handshake; then next command accepted.
- Assert rst during ACCESS → psel, penable and rsp_valid go 0 asynchronously; cmd_ready=1 and no response after rst deasserts.
